uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one UART transmit engine between `NUM_REQ` byte producers. Each producer holds a request with a byte; the arbiter grants one at a time, latches its byte, starts the transmit engine, and waits for the frame to finish before serving the next. It sits between the producer blocks and the UART transmitter, and everything runs in the system `clk` domain.

---
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit engine between NUM_REQ byte producers.
// Optional per-frame timeout with ABORT state is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 2_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ack_o,
    output logic                          tx_start_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    input  logic                          tx_busy_i,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
    output logic                          busy_o,
    output logic                          timeout_err_o
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StStart,
        StWaitDone
`ifdef UART_ARB_TIMEOUT_EN
        , StAbort
`endif
    } state_e;

    state_e                  state_q, state_d;
    logic [IdW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]      req_ack_q, req_ack_d;
    logic                    tx_start_q, tx_start_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic [IdW-1:0]          grant_id_q, grant_id_d;
    logic                    busy_q, busy_d;

    logic                    win_found;
    logic [IdW-1:0]          win_idx;
    logic [IdW-1:0]          cand;
    logic [DATA_WIDTH-1:0]   win_data;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_err_q, timeout_err_d;
`endif

    // First set request scanning upward from rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        win_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IdW'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IdW'(i) == win_idx) begin
                win_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        req_ack_d  = '0;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Registered outputs: the GRANT-cycle values are loaded on entry.
                if (win_found) begin
                    state_d            = StGrant;
                    req_ack_d[win_idx] = 1'b1;
                    tx_data_d          = win_data;
                    grant_id_d         = win_idx;
                    rr_ptr_d           = (win_idx == IdW'(NUM_REQ - 1)) ? '0
                                                                        : win_idx + IdW'(1);
                end
            end
            StGrant: begin
                state_d    = StStart;
                tx_start_d = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d      = '0;
`endif
            end
            StStart: begin
                if (tx_busy_i) begin
                    tx_start_d = 1'b0;
                    state_d    = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!tx_busy_i) state_d = StIdle;
            end
`ifdef UART_ARB_TIMEOUT_EN
            StAbort: state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase
`ifdef UART_ARB_TIMEOUT_EN
        if ((state_q == StStart || state_q == StWaitDone) && state_d != StIdle) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_d == CntW'(TIMEOUT - 1)) begin
                state_d       = StAbort;
                tx_start_d    = 1'b0;
                timeout_err_d = 1'b1;
            end
        end
`endif
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            req_ack_q  <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            req_ack_q  <= req_ack_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign timeout_err_o = timeout_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_err_o  = 1'b0;
`endif

    assign req_ack_o  = req_ack_q;
    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
    assign grant_id_o = grant_id_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed table, corner sequences and random frames
// against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_ack_o;
    logic        tx_start_o;
    logic [7:0]  tx_data_o;
    logic        tx_busy_i;
    logic [1:0]  grant_id_o;
    logic        busy_o;
    logic        timeout_err_o;

    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_ptr = 0;

    uart_tx_arbiter #(
        .NUM_REQ   (4),
        .DATA_WIDTH(8),
        .TIMEOUT   (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .req_data_i   (req_data_i),
        .req_ack_o    (req_ack_o),
        .tx_start_o   (tx_start_o),
        .tx_data_o    (tx_data_o),
        .tx_busy_i    (tx_busy_i),
        .grant_id_o   (grant_id_o),
        .busy_o       (busy_o),
        .timeout_err_o(timeout_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        int         grant;
    } vec_t;

    vec_t tbl[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Round-robin rule: first set bit at or after ptr, wrapping.
    function automatic int pick(input logic [3:0] m, input int p);
        for (int k = 0; k < 4; k++) begin
            if (m[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] d, input int w);
        return d[w*8 +: 8];
    endfunction

    // Called in an IDLE cycle with req_i already driven; next cycle must be GRANT.
    task automatic expect_grant(input int w, input logic [7:0] d);
        logic [3:0] a;
        a = 4'b0001 << w;
        tick();
        chk("req_ack", {28'd0, req_ack_o}, {28'd0, a});
        chk("grant_id", {30'd0, grant_id_o}, w);
        chk("tx_data_grant", {24'd0, tx_data_o}, {24'd0, d});
        chk("busy_grant", {31'd0, busy_o}, 1);
        chk("tx_start_grant", {31'd0, tx_start_o}, 0);
        req_i = req_i & ~a;
        exp_ptr = (w + 1) % 4;
    endtask

    // Transmitter emulation from GRANT until back in IDLE; lat<0 raises tx_busy before START.
    task automatic run_frame(input int lat, input int len, input logic [7:0] d,
                             input logic [3:0] late);
        if (lat < 0) tx_busy_i = 1'b1;
        tick();
        chk("tx_start_on", {31'd0, tx_start_o}, 1);
        chk("tx_data_start", {24'd0, tx_data_o}, {24'd0, d});
        chk("req_ack_start", {28'd0, req_ack_o}, 0);
        for (int k = 0; k < lat; k++) begin
            tick();
            chk("tx_start_hold", {31'd0, tx_start_o}, 1);
        end
        tx_busy_i = 1'b1;
        tick();
        chk("tx_start_off", {31'd0, tx_start_o}, 0);
        chk("busy_wait", {31'd0, busy_o}, 1);
        req_i = req_i | late;
        for (int k = 0; k < len - 1; k++) begin
            tick();
            chk("req_ack_wait", {28'd0, req_ack_o}, 0);
            chk("tx_data_wait", {24'd0, tx_data_o}, {24'd0, d});
        end
        tx_busy_i = 1'b0;
        tick();
        chk("busy_idle", {31'd0, busy_o}, 0);
        chk("req_ack_idle", {28'd0, req_ack_o}, 0);
    endtask

    initial begin
        logic [3:0] newbits;
        int         w;

        tbl[0] = '{4'b1111, 0};
        tbl[1] = '{4'b1111, 1};
        tbl[2] = '{4'b1111, 2};
        tbl[3] = '{4'b1111, 3};
        tbl[4] = '{4'b1111, 0};
        tbl[5] = '{4'b0100, 2};
        tbl[6] = '{4'b0101, 0};
        tbl[7] = '{4'b0101, 2};
        tbl[8] = '{4'b1000, 3};

        rst_n      = 1'b0;
        req_i      = '0;
        req_data_i = '0;
        tx_busy_i  = 1'b0;
        #12;
        chk("rst_ack", {28'd0, req_ack_o}, 0);
        chk("rst_start", {31'd0, tx_start_o}, 0);
        chk("rst_data", {24'd0, tx_data_o}, 0);
        chk("rst_id", {30'd0, grant_id_o}, 0);
        chk("rst_busy", {31'd0, busy_o}, 0);
        chk("rst_terr", {31'd0, timeout_err_o}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Contention, wrap and skip.
        for (int i = 0; i < 9; i++) begin
            req_i      = tbl[i].req;
            req_data_i = $urandom;
            expect_grant(tbl[i].grant, byte_of(req_data_i, tbl[i].grant));
            run_frame((i % 3) - 1, 1 + (i % 2), byte_of(req_data_i, tbl[i].grant), 4'b0000);
        end

        // Single request from requester 1.
        req_i      = 4'b0010;
        req_data_i = 32'h0000_5A00;
        expect_grant(1, 8'h5A);
        run_frame(2, 2, 8'h5A, 4'b0000);

        // Requester 3 arrives mid-frame; ack exactly two cycles after tx_busy falls.
        req_i      = 4'b0001;
        req_data_i = 32'hC300_0011;
        expect_grant(0, 8'h11);
        run_frame(1, 3, 8'h11, 4'b1000);
        expect_grant(3, 8'hC3);
        run_frame(0, 1, 8'hC3, 4'b0000);

        // Reset in WAIT_DONE.
        req_i      = 4'b0100;
        req_data_i = 32'h0077_0000;
        expect_grant(2, 8'h77);
        tick();
        tx_busy_i = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_start", {31'd0, tx_start_o}, 0);
        chk("mrst_data", {24'd0, tx_data_o}, 0);
        chk("mrst_busy", {31'd0, busy_o}, 0);
        chk("mrst_id", {30'd0, grant_id_o}, 0);
        tx_busy_i = 1'b0;
        req_i     = '0;
        tick();
        rst_n   = 1'b1;
        exp_ptr = 0;
        tick();
        chk("mrst_noack", {28'd0, req_ack_o}, 0);
        req_i      = 4'b1010;
        req_data_i = 32'h0000_4400;
        expect_grant(1, 8'h44);
        run_frame(0, 2, 8'h44, 4'b0000);

        // Random frames; held requests carry over, fresh bytes only for newly raised bits.
        for (int n = 0; n < 40; n++) begin
            newbits = 4'($urandom_range(0, 15)) & ~req_i;
            for (int b = 0; b < 4; b++) begin
                if (newbits[b]) req_data_i[b*8 +: 8] = 8'($urandom);
            end
            req_i = req_i | newbits;
            if (req_i == 4'b0000) begin
                req_i[exp_ptr] = 1'b1;
                req_data_i[exp_ptr*8 +: 8] = 8'($urandom);
            end
            w = pick(req_i, exp_ptr);
            expect_grant(w, byte_of(req_data_i, w));
            run_frame(int'($urandom_range(0, 4)) - 1, int'($urandom_range(1, 4)),
                      byte_of(req_data_i, w), 4'b0000);
        end

`ifdef UART_ARB_TIMEOUT_EN
        req_i      = 4'b0001 << exp_ptr;
        req_data_i = 32'h9999_9999;
        expect_grant(pick(req_i, exp_ptr), 8'h99);
        tx_busy_i = 1'b1;
        for (int k = 0; k < 15; k++) tick();
        chk("terr_early", {31'd0, timeout_err_o}, 0);
        tick();
        chk("terr_set", {31'd0, timeout_err_o}, 1);
        chk("terr_start", {31'd0, tx_start_o}, 0);
        tick();
        chk("terr_idle", {31'd0, busy_o}, 0);
        tx_busy_i  = 1'b0;
        req_i      = 4'b0001 << exp_ptr;
        req_data_i = 32'h2222_2222;
        expect_grant(pick(req_i, exp_ptr), 8'h22);
        run_frame(0, 1, 8'h22, 4'b0000);
        chk("terr_sticky", {31'd0, timeout_err_o}, 1);
`else
        chk("terr_zero", {31'd0, timeout_err_o}, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
